// File: rtl/dmem_dump_ctrl.sv
// Data-SRAM read-back engine: streams BASE..BASE+LEN-1 out over valid/ready.
// Optional DMEM_DUMP_CHECKSUM_EN adds DUMP_SUM, the sum of every accepted word.
module dmem_dump_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              DUMP_START,
  input  logic [ADDR_W-1:0] DUMP_BASE,
  input  logic [LEN_W-1:0]  DUMP_LEN,
  output logic              DUMP_BUSY,
  output logic              DUMP_DONE,
  output logic              DUMP_CTRL,
  output logic              MEM_csb0,
  output logic              MEM_web0,
  output logic [ADDR_W-1:0] MEM_addr0,
  input  logic [DATA_W-1:0] MEM_dout0,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [ADDR_W-1:0] OUT_ADDR
`ifdef DMEM_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] DUMP_SUM
`endif
);

  // state | meaning
  // IDLE  | waiting for DUMP_START
  // READ  | issuing reads while credit allows
  // DRAIN | all reads issued, emptying in-flight read and FIFO
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    issued_q;
  logic                inflight_q;
  logic [ADDR_W-1:0]   inflight_addr_q;
  logic [DATA_W-1:0]   fifo_data_q [2];
  logic [ADDR_W-1:0]   fifo_addr_q [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          fifo_cnt_q;

  logic                start_acc, issue, push, pop;
  logic [2:0]          occ;

  assign push = inflight_q;
  assign pop  = (fifo_cnt_q != 2'd0) && OUT_READY;
  // Occupancy after this edge's pop; keeps 1 word/clk with READY held high.
  assign occ  = {2'b00, inflight_q} + {1'b0, fifo_cnt_q} - {2'b00, pop};

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    issue     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (DUMP_START) begin
          start_acc = 1'b1;
          state_d   = (DUMP_LEN == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if ((issued_q != len_q) && (occ < 3'd2)) begin
          issue = 1'b1;
          if ((issued_q + LEN_W'(1)) == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight_q && ((fifo_cnt_q == 2'd0) || ((fifo_cnt_q == 2'd1) && pop)))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign DUMP_BUSY = (state_q == S_READ) || (state_q == S_DRAIN);
  assign DUMP_CTRL = DUMP_BUSY;
  assign DUMP_DONE = (state_q == S_DONE);
  assign MEM_csb0  = ~issue;
  assign MEM_web0  = 1'b1;
  assign MEM_addr0 = base_q + issued_q[ADDR_W-1:0];
  assign OUT_VALID = (fifo_cnt_q != 2'd0);
  assign OUT_DATA  = fifo_data_q[rd_ptr_q];
  assign OUT_ADDR  = fifo_addr_q[rd_ptr_q];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q         <= S_IDLE;
      base_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      fifo_cnt_q      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        base_q   <= DUMP_BASE;
        len_q    <= DUMP_LEN;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + LEN_W'(1);
      end
      inflight_q <= issue;
      if (issue) inflight_addr_q <= MEM_addr0;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= MEM_dout0;
        fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)          sum_q <= '0;
    else if (start_acc) sum_q <= '0;
    else if (pop)       sum_q <= sum_q + OUT_DATA;
  end

  assign DUMP_SUM = sum_q;
`endif

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Bench for dmem_dump_ctrl: SRAM model, scoreboard of expected (addr,data) words.
`timescale 1ns/1ps
module tb_dmem_dump_ctrl;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 11;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              DUMP_START = 1'b0;
  logic [ADDR_W-1:0] DUMP_BASE = '0;
  logic [LEN_W-1:0]  DUMP_LEN = '0;
  logic              DUMP_BUSY, DUMP_DONE, DUMP_CTRL;
  logic              MEM_csb0, MEM_web0;
  logic [ADDR_W-1:0] MEM_addr0;
  logic [DATA_W-1:0] MEM_dout0;
  logic              OUT_VALID;
  logic              OUT_READY = 1'b1;
  logic [DATA_W-1:0] OUT_DATA;
  logic [ADDR_W-1:0] OUT_ADDR;
`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] DUMP_SUM;
`endif

  always #5 CLK = ~CLK;

  dmem_dump_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .DUMP_START(DUMP_START), .DUMP_BASE(DUMP_BASE), .DUMP_LEN(DUMP_LEN),
    .DUMP_BUSY(DUMP_BUSY), .DUMP_DONE(DUMP_DONE), .DUMP_CTRL(DUMP_CTRL),
    .MEM_csb0(MEM_csb0), .MEM_web0(MEM_web0), .MEM_addr0(MEM_addr0),
    .MEM_dout0(MEM_dout0),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_ADDR(OUT_ADDR)
`ifdef DMEM_DUMP_CHECKSUM_EN
    , .DUMP_SUM(DUMP_SUM)
`endif
  );

  // synchronous-read SRAM model
  logic [DATA_W-1:0] mem [1024];
  always @(posedge CLK) if (MEM_csb0 === 1'b0) MEM_dout0 <= mem[MEM_addr0];

  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [DATA_W-1:0] exp_data_q [$];
  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int issue_cnt = 0;
  int done_cnt = 0;
  bit prev_stall = 0;
  logic [DATA_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_addr;

  always @(negedge CLK) begin
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    if (!RSTn) begin
      prev_stall = 0;
      issue_cnt  = acc_cnt;
    end else begin
      if (prev_stall) begin
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== prev_data || OUT_ADDR !== prev_addr) begin
          failures++;
          $display("FAIL stall_hold: valid=%b data=%h addr=%h, required valid=1 data=%h addr=%h",
                   OUT_VALID, OUT_DATA, OUT_ADDR, prev_data, prev_addr);
        end
      end
      if (MEM_csb0 === 1'b0) begin
        issue_cnt++;
        checks++;
        if (DUMP_CTRL !== 1'b1 || MEM_web0 !== 1'b1) begin
          failures++;
          $display("FAIL read_ownership: ctrl=%b web0=%b, required ctrl=1 web0=1", DUMP_CTRL, MEM_web0);
        end
      end
      if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        acc_cnt++;
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got addr=%h data=%h, required no word", OUT_ADDR, OUT_DATA);
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          if (OUT_ADDR !== ea || OUT_DATA !== ed) begin
            failures++;
            $display("FAIL word: got addr=%h data=%h, required addr=%h data=%h", OUT_ADDR, OUT_DATA, ea, ed);
          end
        end
      end
      if (issue_cnt - acc_cnt > 2) begin
        checks++;
        failures++;
        $display("FAIL read_ahead: %0d reads ahead, required <= 2", issue_cnt - acc_cnt);
      end
      if (DUMP_DONE === 1'b1) done_cnt++;
      prev_stall = (OUT_VALID === 1'b1 && OUT_READY !== 1'b1);
      prev_data  = OUT_DATA;
      prev_addr  = OUT_ADDR;
    end
  end

  task automatic do_start(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
    logic [ADDR_W-1:0] a;
    @(posedge CLK); #1;
    DUMP_START = 1'b1;
    DUMP_BASE  = base;
    DUMP_LEN   = len;
    for (int i = 0; i < int'(len); i++) begin
      a = base + ADDR_W'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem[a]);
    end
    @(posedge CLK); #1;
    DUMP_START = 1'b0;
    DUMP_BASE  = ADDR_W'($urandom);
    DUMP_LEN   = LEN_W'($urandom_range(1, 5));
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge CLK); #1;
      if (DUMP_DONE === 1'b1) seen = 1;
    end
  endtask

  task automatic test_reset;
    logic [5:0] obs;
    RSTn = 1'b0;
    #23;
    obs = {DUMP_BUSY, DUMP_DONE, DUMP_CTRL, MEM_csb0, MEM_web0, OUT_VALID};
    checks++;
    if (obs !== 6'b000110) begin
      failures++;
      $display("FAIL reset_ctrl: busy,done,ctrl,csb0,web0,valid=%b, required 000110", obs);
    end
    checks++;
    if (MEM_addr0 !== '0 || OUT_DATA !== '0 || OUT_ADDR !== '0) begin
      failures++;
      $display("FAIL reset_data: addr0=%h data=%h addr=%h, required 0 0 0", MEM_addr0, OUT_DATA, OUT_ADDR);
    end
`ifdef DMEM_DUMP_CHECKSUM_EN
    checks++;
    if (DUMP_SUM !== '0) begin
      failures++;
      $display("FAIL reset_sum: sum=%h, required 0", DUMP_SUM);
    end
`endif
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic test_basic;
    OUT_READY = 1'b1;
    mem[10'h1C] = 32'h2;
    mem[10'h1D] = 32'h5;
    do_start(10'h1C, 11'd2);
    @(negedge CLK);
    checks++;
    if ({DUMP_BUSY, DUMP_CTRL, MEM_csb0, OUT_VALID} !== 4'b1100 || MEM_addr0 !== 10'h1C) begin
      failures++;
      $display("FAIL basic_c1: busy,ctrl,csb0,valid=%b%b%b%b addr0=%h, required 1100 addr0=01c",
               DUMP_BUSY, DUMP_CTRL, MEM_csb0, OUT_VALID, MEM_addr0);
    end
    @(negedge CLK);
    checks++;
    if (MEM_csb0 !== 1'b0 || MEM_addr0 !== 10'h1D || OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL basic_c2: csb0=%b addr0=%h valid=%b, required 0 01d 0", MEM_csb0, MEM_addr0, OUT_VALID);
    end
    @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_ADDR !== 10'h1C || OUT_DATA !== 32'h2 || MEM_csb0 !== 1'b1) begin
      failures++;
      $display("FAIL basic_w0: valid=%b addr=%h data=%h csb0=%b, required 1 01c 2 1",
               OUT_VALID, OUT_ADDR, OUT_DATA, MEM_csb0);
    end
    @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_ADDR !== 10'h1D || OUT_DATA !== 32'h5) begin
      failures++;
      $display("FAIL basic_w1: valid=%b addr=%h data=%h, required 1 01d 5", OUT_VALID, OUT_ADDR, OUT_DATA);
    end
    @(negedge CLK);
    checks++;
    if ({DUMP_DONE, DUMP_BUSY, DUMP_CTRL, OUT_VALID} !== 4'b1000) begin
      failures++;
      $display("FAIL basic_done: done,busy,ctrl,valid=%b%b%b%b, required 1000",
               DUMP_DONE, DUMP_BUSY, DUMP_CTRL, OUT_VALID);
    end
`ifdef DMEM_DUMP_CHECKSUM_EN
    checks++;
    if (DUMP_SUM !== 32'h7) begin
      failures++;
      $display("FAIL basic_sum: sum=%h, required 7", DUMP_SUM);
    end
`endif
    @(negedge CLK);
    checks++;
    if (DUMP_DONE !== 1'b0 || DUMP_BUSY !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle: done=%b busy=%b, required 0 0", DUMP_DONE, DUMP_BUSY);
    end
  endtask

  task automatic test_len0;
    do_start(10'h055, 11'd0);
    @(negedge CLK);
    checks++;
    if ({DUMP_DONE, DUMP_BUSY, DUMP_CTRL, MEM_csb0, OUT_VALID} !== 5'b10010) begin
      failures++;
      $display("FAIL len0_done: done,busy,ctrl,csb0,valid=%b%b%b%b%b, required 10010",
               DUMP_DONE, DUMP_BUSY, DUMP_CTRL, MEM_csb0, OUT_VALID);
    end
    @(negedge CLK);
    checks++;
    if ({DUMP_DONE, MEM_csb0, OUT_VALID} !== 3'b010) begin
      failures++;
      $display("FAIL len0_after: done,csb0,valid=%b%b%b, required 010", DUMP_DONE, MEM_csb0, OUT_VALID);
    end
  endtask

  task automatic test_wrap;
    bit seen;
    OUT_READY = 1'b1;
    do_start(10'h3FE, 11'd4);
    wait_done(20, seen);
    checks++;
    if (!seen || exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_done: done_seen=%0d words_left=%0d, required 1 0", seen, exp_addr_q.size());
    end
  endtask

  task automatic test_stall;
    bit seen = 0;
    int acc0 = acc_cnt;
    do_start(10'h040, 11'd8);
    for (int k = 0; k < 200 && !seen; k++) begin
      OUT_READY  = (k % 4 == 0) || (k % 4 == 3);
      DUMP_START = (k == 4);
      if (k == 4) begin
        DUMP_BASE = 10'h200;
        DUMP_LEN  = 11'd5;
      end
      @(negedge CLK); #1;
      if (DUMP_DONE === 1'b1) seen = 1;
      @(posedge CLK); #1;
    end
    DUMP_START = 1'b0;
    OUT_READY  = 1'b1;
    checks++;
    if (!seen || exp_addr_q.size() != 0 || acc_cnt - acc0 != 8) begin
      failures++;
      $display("FAIL stall_done: done_seen=%0d words_left=%0d accepted=%0d, required 1 0 8",
               seen, exp_addr_q.size(), acc_cnt - acc0);
    end
  endtask

  task automatic test_full;
    bit seen;
    int acc0;
    for (int i = 0; i < 1024; i++) mem[i] = DATA_W'(i);
    OUT_READY = 1'b1;
    acc0 = acc_cnt;
    do_start(10'h000, 11'd1024);
    wait_done(1200, seen);
    checks++;
    if (!seen || exp_addr_q.size() != 0 || acc_cnt - acc0 != 1024) begin
      failures++;
      $display("FAIL full_done: done_seen=%0d words_left=%0d accepted=%0d, required 1 0 1024",
               seen, exp_addr_q.size(), acc_cnt - acc0);
    end
`ifdef DMEM_DUMP_CHECKSUM_EN
    checks++;
    if (DUMP_SUM !== 32'h0007FE00) begin
      failures++;
      $display("FAIL full_sum: sum=%h, required 0007fe00", DUMP_SUM);
    end
    @(negedge CLK);
    checks++;
    if (DUMP_SUM !== 32'h0007FE00) begin
      failures++;
      $display("FAIL full_sum_hold: sum=%h, required 0007fe00", DUMP_SUM);
    end
`endif
  endtask

  task automatic test_reset_mid;
    bit seen;
    int acc0, done0;
    logic [5:0] obs;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    OUT_READY = 1'b1;
    acc0 = acc_cnt;
    do_start(10'h010, 11'd8);
    for (int k = 0; k < 20 && (acc_cnt - acc0) < 3; k++) begin
      @(negedge CLK); #1;
    end
    checks++;
    if (acc_cnt - acc0 != 3) begin
      failures++;
      $display("FAIL mid_progress: accepted=%0d, required 3", acc_cnt - acc0);
    end
    @(posedge CLK); #2;
    done0 = done_cnt;
    RSTn  = 1'b0;
    #1;
    obs = {DUMP_BUSY, DUMP_DONE, DUMP_CTRL, MEM_csb0, MEM_web0, OUT_VALID};
    checks++;
    if (obs !== 6'b000110 || MEM_addr0 !== '0 || OUT_DATA !== '0 || OUT_ADDR !== '0) begin
      failures++;
      $display("FAIL mid_async: busy,done,ctrl,csb0,web0,valid=%b addr0=%h data=%h addr=%h, required 000110 0 0 0",
               obs, MEM_addr0, OUT_DATA, OUT_ADDR);
    end
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (3) @(negedge CLK);
    @(posedge CLK); #1;
    RSTn = 1'b1;
    checks++;
    if (done_cnt != done0 || DUMP_DONE !== 1'b0) begin
      failures++;
      $display("FAIL mid_nodone: done pulses=%0d done=%b, required 0 0", done_cnt - done0, DUMP_DONE);
    end
    do_start(10'h010, 11'd4);
    wait_done(20, seen);
    checks++;
    if (!seen || exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL mid_restart: done_seen=%0d words_left=%0d, required 1 0", seen, exp_addr_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_stall();
    test_full();
    test_reset_mid();
    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
